slot_machine_gen: RTL

Parametrised, credit-tracking slot-machine core: N reels, each advancing at its own divided rate. Reels are started by one button press and stopped one at a time, left to right, by later presses. When all reels are stopped the block evaluates the result, pays out on a jackpot, and blinks/buzzes for a fixed window. It replaces the fixed three-reel top level. It drives symbol codes to the existing display encoder, and the display encoder is not part of this block.

---
 rtl/slot_machine_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/slot_machine_gen.sv
// Credit-tracking slot-machine core: N reels at individually divided rates,
// started by one press, stopped left to right, with a jackpot payout and blink window.
module slot_machine_gen #(
    parameter int REELS         = 3,
    parameter int SYMBOLS       = 10,
    parameter int DIV_W         = 20,
    parameter int BASE_DIV      = 10,
    parameter int DIV_STEP      = 3,
    parameter int CREDIT_W      = 8,
    parameter int INIT_CREDITS  = 5,
    parameter int PAYOUT        = 10,
    parameter int RESULT_CYCLES = 64,
    parameter int BLINK_DIV     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button,
    output logic [REELS*4-1:0]    reel_syms,
    output logic [REELS-1:0]      reel_stopped,
    output logic                  blank,
    output logic                  buzzer,
    output logic [CREDIT_W-1:0]   credits,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SPIN, EVAL, RESULT} state_t;

    localparam int NS_W    = $clog2(REELS);
    localparam int RT_W    = $clog2(RESULT_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [3:0]          SYM_LAST   = 4'(SYMBOLS - 1);
    localparam logic [NS_W-1:0]     LAST_REEL  = NS_W'(REELS - 1);
    localparam logic [RT_W-1:0]     RT_LAST    = RT_W'(RESULT_CYCLES - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    state_t               state;
    logic                 btn_prev;
    logic                 press;
    logic [NS_W-1:0]      next_stop;
    logic [DIV_W-1:0]     div_cnt [REELS];
    logic [RT_W-1:0]      timer;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 all_equal;
    logic [CREDIT_W:0]    credit_sum;

    function automatic logic [DIV_W-1:0] period_last(input int idx);
        return DIV_W'(BASE_DIV + idx * DIV_STEP - 1);
    endfunction

    always_comb begin
        all_equal = 1'b1;
        for (int i = 1; i < REELS; i++) begin
            if (reel_syms[4*i +: 4] != reel_syms[3:0]) all_equal = 1'b0;
        end
        credit_sum = {1'b0, credits} + (CREDIT_W + 1)'(PAYOUT);
    end

    // The press is registered one edge before the FSM consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            btn_prev     <= 1'b0;
            press        <= 1'b0;
            next_stop    <= '0;
            reel_syms    <= '0;
            reel_stopped <= '1;
            credits      <= CREDIT_W'(INIT_CREDITS);
            blank        <= 1'b0;
            buzzer       <= 1'b0;
            busy         <= 1'b0;
            timer        <= '0;
            blink_cnt    <= '0;
            for (int i = 0; i < REELS; i++) div_cnt[i] <= '0;
        end else begin
            btn_prev <= button;
            press    <= button & ~btn_prev;
            case (state)
                IDLE: begin
                    if (press && credits != '0) begin
                        credits      <= credits - CREDIT_W'(1);
                        reel_stopped <= '0;
                        next_stop    <= '0;
                        busy         <= 1'b1;
                        state        <= SPIN;
                    end
                end
                SPIN: begin
                    // A stop wins over an advance due on the same edge.
                    for (int i = 0; i < REELS; i++) begin
                        if (press && next_stop == NS_W'(i)) begin
                            reel_stopped[i] <= 1'b1;
                            div_cnt[i]      <= '0;
                        end else if (!reel_stopped[i]) begin
                            if (div_cnt[i] == period_last(i)) begin
                                div_cnt[i] <= '0;
                                reel_syms[4*i +: 4] <= (reel_syms[4*i +: 4] == SYM_LAST)
                                                     ? 4'd0 : reel_syms[4*i +: 4] + 4'd1;
                            end else begin
                                div_cnt[i] <= div_cnt[i] + DIV_W'(1);
                            end
                        end
                    end
                    if (press) begin
                        next_stop <= next_stop + NS_W'(1);
                        if (next_stop == LAST_REEL) state <= EVAL;
                    end
                end
                EVAL: begin
                    if (all_equal) begin
                        credits <= (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                                             : credit_sum[CREDIT_W-1:0];
                    end
                    buzzer    <= all_equal;
                    blank     <= 1'b0;
                    timer     <= '0;
                    blink_cnt <= '0;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (timer == RT_LAST) begin
                        blank  <= 1'b0;
                        buzzer <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + RT_W'(1);
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            if (buzzer) blank <= ~blank;
                        end else begin
                            blink_cnt <= blink_cnt + BLINK_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
